aes_key_loader: RTL

AES_KEY_LOADER -- requirements
Module: aes_key_loader

---
 rtl/aes_key_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/aes_key_loader.sv
// Byte-serial AES key loader: a mode byte picks AES-128/192/256, then 16/24/32 key bytes shift into key_out.
// Optional LOAD idle timeout is compiled in with `define AES_KEY_TIMEOUT_EN.
module aes_key_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   output logic [255:0] key_out,
   output logic [3:0]   nk,
   output logic [3:0]   nr,
   output logic         key_valid,
   output logic         err
);

   typedef enum logic [1:0] {MODE, LOAD, DONE, ERR} state_t;

   state_t         state, state_nxt;
   logic [255:0]   key_nxt;
   logic [3:0]     nk_nxt, nr_nxt;
   logic [5:0]     cnt, cnt_nxt;
   logic           valid_nxt, err_nxt;
   logic           xfer;
   logic           timeout_hit;

   assign in_ready = rst_n && ((state == MODE) || (state == LOAD));
   assign xfer     = in_valid && in_ready;

`ifdef AES_KEY_TIMEOUT_EN
   localparam int IDLE_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [IDLE_W-1:0] idle_cnt;

   // Counts consecutive LOAD cycles without a transfer; fires on the TIMEOUT_CYCLES-th one.
   always_ff @(posedge clk) begin
      if (!rst_n || clear || (state != LOAD) || xfer)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 1'b1;
   end

   assign timeout_hit = (state == LOAD) && !xfer &&
                        (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
   // Timer compiled out; this folds to a constant 0.
   assign timeout_hit = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= MODE;
         key_out   <= '0;
         nk        <= '0;
         nr        <= '0;
         cnt       <= '0;
         key_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         key_out   <= key_nxt;
         nk        <= nk_nxt;
         nr        <= nr_nxt;
         cnt       <= cnt_nxt;
         key_valid <= valid_nxt;
         err       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      key_nxt   = key_out;
      nk_nxt    = nk;
      nr_nxt    = nr;
      cnt_nxt   = cnt;
      valid_nxt = key_valid;
      err_nxt   = err;

      case (state)
         MODE: begin
            if (xfer) begin
               key_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = LOAD;
               case (in_data)
                  8'h00: begin nk_nxt = 4'd4; nr_nxt = 4'd10; end
                  8'h01: begin nk_nxt = 4'd6; nr_nxt = 4'd12; end
                  8'h02: begin nk_nxt = 4'd8; nr_nxt = 4'd14; end
                  default: begin
                     state_nxt = ERR;
                     err_nxt   = 1'b1;
                  end
               endcase
            end
         end
         LOAD: begin
            if (timeout_hit) begin
               state_nxt = ERR;
               err_nxt   = 1'b1;
               key_nxt   = '0;
            end else if (xfer) begin
               key_nxt = {key_out[247:0], in_data};
               cnt_nxt = cnt + 6'd1;
               // 4*nk bytes complete the key
               if ((cnt + 6'd1) == {nk, 2'b00}) begin
                  state_nxt = DONE;
                  valid_nxt = 1'b1;
               end
            end
         end
         DONE: begin
         end
         ERR: begin
         end
         default: state_nxt = MODE;
      endcase

      if (clear) begin
         state_nxt = MODE;
         key_nxt   = '0;
         nk_nxt    = '0;
         nr_nxt    = '0;
         cnt_nxt   = '0;
         valid_nxt = 1'b0;
         err_nxt   = 1'b0;
      end
   end

endmodule
